pulse_meter: RTL

Receive-side measurement block for the optical synchronizing pulse chain. It is armed by a start level, waits for an incoming (asynchronous) pulse on `pl_in`, and measures two values in `clk_Meter` cycles: the delay from arming to the pulse's rising edge, and the pulse's high width. It presents the results through a valid/ack handshake and raises a flag on timeout. It sits at the far end of the pulse generator / delay-line path and closes the loop for calibration and self-test.

---
 rtl/pulse_meter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pulse_meter.sv
// pulse_meter: measures the delay from arming to a pulse's rising edge and the
// pulse's high width, both in clk_Meter cycles, and hands the result over
// through a valid/ack handshake. The pulse input is asynchronous; it is
// synchronized and glitch-filtered, and the fixed conditioning latency is
// removed from the reported delay.
module pulse_meter #(
    parameter int CNT_W = 26,
    parameter int FILT  = 2
) (
    input  logic             clk_Meter,
    input  logic             rst_Meter_n,
    input  logic             arm,
    input  logic             pl_in,
    input  logic [CNT_W-1:0] timeout,
    input  logic             res_ack,
    output logic [CNT_W-1:0] delay,
    output logic [CNT_W-1:0] width,
    output logic             res_valid,
    output logic             timeout_err,
    output logic             busy
);

    // Conditioning latency from pl_in to pl_f: two synchronizer stages plus
    // FILT filter samples. Both edges see the same latency.
    localparam logic [CNT_W-1:0] LAT     = CNT_W'(2 + FILT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d;
    logic [FILT-1:0]  hist_q, hist_d;
    logic             pl_f_q, pl_f_d, pl_fd_q, pl_fd_d;
    logic             arm_q, arm_d;
    logic [CNT_W-1:0] raw_dly_q, raw_dly_d, wcnt_q, wcnt_d;
    logic [CNT_W-1:0] delay_q, delay_d, width_q, width_d;
    logic             res_valid_q, res_valid_d;
    logic             timeout_err_q, timeout_err_d;
    logic             busy_q, busy_d;

    logic             pl_rise, pl_fall, arm_rise;
    logic [CNT_W-1:0] raw_inc, wcnt_inc, dly_corr;
    logic             wait_tmo, meas_tmo;

    // Filter history: the last FILT synchronized samples, newest in bit 0.
    generate
        if (FILT == 1) begin : g_hist_one
            always_comb hist_d = s2_q;
        end else begin : g_hist_many
            always_comb hist_d = {hist_q[FILT-2:0], s2_q};
        end
    endgenerate

    // Synchronizer, filter decision and edge-history next values.
    always_comb begin
        s1_d    = pl_in;
        s2_d    = s1_q;
        pl_fd_d = pl_f_q;
        arm_d   = arm;
        pl_f_d  = pl_f_q;
        if (&hist_q) begin
            pl_f_d = 1'b1;
        end else if (~|hist_q) begin
            pl_f_d = 1'b0;
        end
    end

    // Edge detection, saturating increments and limit comparisons.
    always_comb begin
        pl_rise  = pl_f_q & ~pl_fd_q;
        pl_fall  = ~pl_f_q & pl_fd_q;
        arm_rise = arm & ~arm_q;
        raw_inc  = (raw_dly_q == CNT_MAX) ? raw_dly_q : raw_dly_q + 1'b1;
        wcnt_inc = (wcnt_q == CNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
        dly_corr = (raw_dly_q >= LAT) ? raw_dly_q - LAT : '0;
        wait_tmo = (timeout != '0) && (dly_corr >= timeout);
        meas_tmo = (timeout != '0) && (wcnt_q >= timeout);
    end

    // Measurement FSM: abort beats edges, edges beat timeouts.
    always_comb begin
        state_d       = state_q;
        raw_dly_d     = raw_dly_q;
        wcnt_d        = wcnt_q;
        delay_d       = delay_q;
        width_d       = width_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (arm_rise) begin
                    state_d   = WAIT_RISE;
                    raw_dly_d = '0;
                    wcnt_d    = '0;
                end
            end
            WAIT_RISE: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (pl_rise) begin
                    state_d = MEAS_HIGH;
                    wcnt_d  = CNT_W'(1);
                end else if (wait_tmo) begin
                    state_d       = DONE;
                    delay_d       = timeout;
                    width_d       = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    raw_dly_d = raw_inc;
                end
            end
            MEAS_HIGH: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (pl_fall) begin
                    state_d       = DONE;
                    delay_d       = dly_corr;
                    width_d       = wcnt_q;
                    timeout_err_d = 1'b0;
                end else if (meas_tmo) begin
                    state_d       = DONE;
                    delay_d       = dly_corr;
                    width_d       = timeout;
                    timeout_err_d = 1'b1;
                end else if (pl_f_q) begin
                    wcnt_d = wcnt_inc;
                end
            end
            DONE: begin
                if (res_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d == WAIT_RISE) || (state_d == MEAS_HIGH);
        res_valid_d = (state_d == DONE);
    end

    // State and datapath registers; reset discards any measurement in flight.
    always_ff @(posedge clk_Meter or negedge rst_Meter_n) begin
        if (!rst_Meter_n) begin
            state_q       <= IDLE;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            hist_q        <= '0;
            pl_f_q        <= 1'b0;
            pl_fd_q       <= 1'b0;
            arm_q         <= 1'b0;
            raw_dly_q     <= '0;
            wcnt_q        <= '0;
            delay_q       <= '0;
            width_q       <= '0;
            res_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            hist_q        <= hist_d;
            pl_f_q        <= pl_f_d;
            pl_fd_q       <= pl_fd_d;
            arm_q         <= arm_d;
            raw_dly_q     <= raw_dly_d;
            wcnt_q        <= wcnt_d;
            delay_q       <= delay_d;
            width_q       <= width_d;
            res_valid_q   <= res_valid_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign delay       = delay_q;
    assign width       = width_q;
    assign res_valid   = res_valid_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule
